// File: rtl/spi_slave_sync.sv
// ============================================================================
// Module      : spi_slave_sync
// Description : SPI slave (all CPOL/CPHA modes, MSB first) that oversamples
//               sclk/csb/din on the system clock. Optional overrun flag is
//               enabled by defining SPI_SLAVE_SYNC_OVERRUN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_sync #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic                  sclk,
    input  logic                  csb,
    input  logic                  din,
    output logic                  dout,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  rx_overrun,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // [0],[1] synchronizer stages, [2] history flop for edge detection
    logic [2:0]            r_sclk_sync;
    logic [2:0]            r_csb_sync;
    logic [2:0]            r_din_sync;

    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-2:0] r_rx_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_tx_ready;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;

    logic                  w_sclk_edge;
    logic                  w_lead;
    logic                  w_trail;
    logic                  w_sample;
    logic                  w_shift;
    logic                  w_csb_fall;
    logic                  w_csb_rise;
    logic                  w_active;
    logic                  w_done;
    logic                  w_word_start;
    logic [DATA_WIDTH-1:0] w_rx_word;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_sclk_sync <= '0;
            r_csb_sync  <= '0;
            r_din_sync  <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_csb_sync  <= {r_csb_sync[1:0], csb};
            r_din_sync  <= {r_din_sync[1:0], din};
        end
    end

    assign w_sclk_edge = r_sclk_sync[1] ^ r_sclk_sync[2];
    assign w_lead      = w_sclk_edge && (r_sclk_sync[1] != CPOL);
    assign w_trail     = w_sclk_edge && (r_sclk_sync[1] == CPOL);
    assign w_sample    = CPHA ? w_trail : w_lead;
    // No shift before the first sample of a word: keeps the MSB on the line
    assign w_shift     = (CPHA ? w_lead : w_trail) && (r_cnt != '0);
    assign w_csb_fall  = !r_csb_sync[1] && r_csb_sync[2];
    assign w_csb_rise  = r_csb_sync[1] && !r_csb_sync[2];
    assign w_active    = (r_state == ACTIVE);
    assign w_done      = w_active && !w_csb_rise && w_sample &&
                         (r_cnt == CNT_W'(DATA_WIDTH - 1));
    assign w_word_start = ((r_state == IDLE) && w_csb_fall) || w_done;
    assign w_rx_word   = {r_rx_shift, r_din_sync[2]};

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state <= WAIT_HIGH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_HIGH: if (r_csb_sync[1]) w_state_nxt = IDLE;
            IDLE:      if (w_csb_fall)    w_state_nxt = ACTIVE;
            ACTIVE:    if (w_csb_rise)    w_state_nxt = IDLE;
            default:                      w_state_nxt = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_hold     <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_cnt      <= '0;
            r_tx_ready <= 1'b1;
        end else if (w_word_start) begin
            r_tx_shift <= tx_load ? tx_data : r_hold;
            r_cnt      <= '0;
            r_tx_ready <= 1'b1;
            if (tx_load) begin
                r_hold <= tx_data;
            end
        end else begin
            if (tx_load) begin
                r_hold     <= tx_data;
                r_tx_ready <= 1'b0;
            end
            if (w_active && w_csb_rise) begin
                r_cnt <= '0;
            end else if (w_active) begin
                if (w_sample) begin
                    r_rx_shift <= w_rx_word[DATA_WIDTH-2:0];
                    r_cnt      <= r_cnt + CNT_W'(1);
                end
                if (w_shift) begin
                    r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else if (w_done) begin
            r_rx_data  <= w_rx_word;
            r_rx_valid <= 1'b1;
        end else if (rx_ack) begin
            r_rx_valid <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_overrun <= 1'b0;
        end else if (rx_ack && r_rx_valid) begin
            r_overrun <= 1'b0;
        end else if (w_done && r_rx_valid) begin
            r_overrun <= 1'b1;
        end
    end

    assign rx_overrun = r_overrun;
`else
    assign rx_overrun = 1'b0;
`endif

    assign dout     = w_active ? r_tx_shift[DATA_WIDTH-1] : 1'b0;
    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = w_active;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
// ============================================================================
// Module      : tb_spi_slave_sync
// Description : Self-checking bench for spi_slave_sync with a bit-banged master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_sync;

`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       resetb  = 1'b0;
    logic       CPOL    = 1'b0;
    logic       CPHA    = 1'b0;
    logic       sclk    = 1'b0;
    logic       csb     = 1'b1;
    logic       din     = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       rx_ack  = 1'b0;
    wire        dout;
    wire        tx_ready;
    wire  [7:0] rx_data;
    wire        rx_valid;
    wire        rx_overrun;
    wire        busy;

    int n_cmp = 0;
    int n_err = 0;
    int half  = 4;

    spi_slave_sync #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .CPOL       (CPOL),
        .CPHA       (CPHA),
        .sclk       (sclk),
        .csb        (csb),
        .din        (din),
        .dout       (dout),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .rx_overrun (rx_overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    // One word as the master sees it; csb must already be low
    task automatic spi_word(input logic [7:0] mosi, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (!CPHA) begin
                din = mosi[i];
                repeat (half) @(negedge clk);
                miso[i] = dout;
                sclk = ~CPOL;
                repeat (half) @(negedge clk);
                sclk = CPOL;
            end else begin
                repeat (half) @(negedge clk);
                sclk = ~CPOL;
                din = mosi[i];
                repeat (half) @(negedge clk);
                miso[i] = dout;
                sclk = CPOL;
            end
        end
        repeat (half) @(negedge clk);
        check1("busy_in_frame", busy, 1'b1);
    endtask

    task automatic xfer(input bit pol, input bit pha, input bit do_load,
                        input logic [7:0] txw, input logic [7:0] mosi,
                        output logic [7:0] miso);
        @(negedge clk);
        CPOL = pol;
        CPHA = pha;
        sclk = pol;
        if (do_load) begin
            load(txw);
            check1("tx_ready_after_load", tx_ready, 1'b0);
        end
        repeat (5) @(negedge clk);
        csb = 1'b0;
        spi_word(mosi, miso);
        csb = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        bit         pol;
        bit         pha;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] m1, m2;
        logic [7:0] m_hold, m_data, txw, mosi;
        bit         m_valid, m_ovr, pol, pha, do_load;

        vecs[0] = '{1'b0, 1'b0, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
        vecs[1] = '{1'b0, 1'b0, 8'h11, 8'hA5, 8'h11, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 8'h22, 8'hA5, 8'h22, 8'hA5};
        vecs[3] = '{1'b1, 1'b0, 8'h33, 8'hA5, 8'h33, 8'hA5};
        vecs[4] = '{1'b1, 1'b1, 8'h44, 8'hA5, 8'h44, 8'hA5};
        vecs[5] = '{1'b1, 1'b0, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[6] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};

        // reset state
        repeat (3) @(negedge clk);
        check1("rst_dout", dout, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_tx_ready", tx_ready, 1'b1);
        check1("rst_rx_valid", rx_valid, 1'b0);
        check1("rst_overrun", rx_overrun, 1'b0);
        check8("rst_rx_data", rx_data, 8'h00);
        resetb = 1'b1;
        repeat (5) @(negedge clk);

        // holding register resets to zero, so an unloaded word returns 0x00
        xfer(1'b0, 1'b0, 1'b0, 8'h00, 8'hC5, m1);
        check8("hold_reset_miso", m1, 8'h00);
        check8("hold_reset_rx", rx_data, 8'hC5);
        ack();

        foreach (vecs[k]) begin
            half = 4;
            xfer(vecs[k].pol, vecs[k].pha, 1'b1, vecs[k].tx, vecs[k].mosi, m1);
            check8("vec_miso", m1, vecs[k].exp_miso);
            check8("vec_rx_data", rx_data, vecs[k].exp_rx);
            check1("vec_rx_valid", rx_valid, 1'b1);
            check1("vec_tx_ready", tx_ready, 1'b1);
            check1("vec_busy_idle", busy, 1'b0);
            check1("vec_dout_idle", dout, 1'b0);
            ack();
            check1("vec_rx_valid_ack", rx_valid, 1'b0);
        end

        // back-to-back words with csb held low
        half = 4;
        @(negedge clk);
        CPOL = 1'b0; CPHA = 1'b0; sclk = 1'b0;
        load(8'h5A);
        repeat (5) @(negedge clk);
        csb = 1'b0;
        fork
            begin
                spi_word(8'h01, m1);
                check8("b2b_miso1", m1, 8'h5A);
                check8("b2b_rx1", rx_data, 8'h01);
                check1("b2b_valid1", rx_valid, 1'b1);
                ack();
                spi_word(8'h02, m2);
            end
            begin
                for (int t = 0; t < 400 && !tx_ready; t++) @(negedge clk);
                check1("b2b_tx_ready_rise", tx_ready, 1'b1);
                load(8'hC3);
            end
        join
        csb = 1'b1;
        repeat (6) @(negedge clk);
        check8("b2b_miso2", m2, 8'hC3);
        check8("b2b_rx2", rx_data, 8'h02);
        check1("b2b_valid2", rx_valid, 1'b1);
        ack();

        // abort after 3 sclk cycles
        load(8'h55);
        repeat (5) @(negedge clk);
        csb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        csb = 1'b1;
        repeat (8) @(negedge clk);
        check1("abort_rx_valid", rx_valid, 1'b0);
        check8("abort_rx_data", rx_data, 8'h02);
        check1("abort_busy", busy, 1'b0);
        xfer(1'b0, 1'b0, 1'b1, 8'h69, 8'h96, m1);
        check8("abort_next_miso", m1, 8'h69);
        check8("abort_next_rx", rx_data, 8'h96);
        check1("abort_next_valid", rx_valid, 1'b1);
        ack();

        // overrun: two words without rx_ack, second resends the held value
        xfer(1'b1, 1'b1, 1'b1, 8'hAA, 8'h12, m1);
        check1("ovr_first", rx_overrun, 1'b0);
        xfer(1'b1, 1'b1, 1'b0, 8'h00, 8'h34, m2);
        check8("ovr_resend", m2, 8'hAA);
        check8("ovr_rx_data", rx_data, 8'h34);
        check1("ovr_flag", rx_overrun, OVR_EN);
        ack();
        check1("ovr_cleared", rx_overrun, 1'b0);
        check1("ovr_valid_cleared", rx_valid, 1'b0);

        // reset mid-frame with csb held low
        @(negedge clk);
        CPOL = 1'b0; CPHA = 1'b0; sclk = 1'b0;
        load(8'h77);
        repeat (5) @(negedge clk);
        csb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        resetb = 1'b0;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        check1("mid_rst_dout", dout, 1'b0);
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_tx_ready", tx_ready, 1'b1);
        check1("mid_rst_rx_valid", rx_valid, 1'b0);
        check1("mid_rst_overrun", rx_overrun, 1'b0);
        check8("mid_rst_rx_data", rx_data, 8'h00);
        for (int i = 0; i < 8; i++) begin
            din = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        check1("mid_rst_no_word", rx_valid, 1'b0);
        check1("mid_rst_not_busy", busy, 1'b0);
        csb = 1'b1;
        repeat (6) @(negedge clk);
        xfer(1'b0, 1'b0, 1'b1, 8'h81, 8'h3C, m1);
        check8("mid_rst_recover_miso", m1, 8'h81);
        check8("mid_rst_recover_rx", rx_data, 8'h3C);
        ack();

        // randomized transactions against a word-level model
        m_hold  = 8'h81;
        m_data  = 8'h3C;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        for (int n = 0; n < 24; n++) begin
            pol     = 1'($urandom_range(0, 1));
            pha     = 1'($urandom_range(0, 1));
            half    = $urandom_range(4, 7);
            do_load = (n == 0) || ($urandom_range(0, 3) != 0);
            txw     = 8'($urandom);
            mosi    = 8'($urandom);
            if (do_load) m_hold = txw;
            xfer(pol, pha, do_load, txw, mosi, m1);
            if (m_valid) m_ovr = OVR_EN;
            m_valid = 1'b1;
            m_data  = mosi;
            check8("rnd_miso", m1, m_hold);
            check8("rnd_rx_data", rx_data, m_data);
            check1("rnd_rx_valid", rx_valid, m_valid);
            check1("rnd_overrun", rx_overrun, m_ovr);
            if ($urandom_range(0, 1) != 0) begin
                ack();
                m_ovr   = 1'b0;
                m_valid = 1'b0;
                check1("rnd_ack_valid", rx_valid, m_valid);
                check1("rnd_ack_overrun", rx_overrun, m_ovr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_slave_sync.md
# spi_slave_sync

Fully synchronous SPI slave that runs on the system clock and oversamples the `sclk`, `csb` and `din` pins rather than clocking logic from `sclk`. It is the responder end of the link driven by `spi_master`. It supports all four CPOL/CPHA modes, sends MSB first, and exchanges full-duplex words of DATA_WIDTH bits. It presents a parallel TX holding register and an RX word interface with a valid/ack handshake to core logic.

## Interface
- DATA_WIDTH, 8, bits per word (≥2)
- clk  input  1  system clock; all logic is clocked on its rising edge
- resetb  input  1  synchronous, active-low reset
- CPOL  input  1  sclk idle level; held static while `busy`
- CPHA  input  1  0: sample on the leading edge; 1: sample on the trailing edge; held static while `busy`
- sclk  input  1  SPI clock from the master, asynchronous to `clk`
- csb  input  1  active-low chip select, asynchronous
- din  input  1  serial data from the master (MOSI), asynchronous
- dout  output  1  serial data to the master (MISO)
- tx_data  input  DATA_WIDTH  next word to transmit
- tx_load  input  1  one-cycle strobe that writes `tx_data` into the holding register
- tx_ready  output  1  holding register consumed; a new load is expected
- rx_data  output  DATA_WIDTH  last complete received word
- rx_valid  output  1  `rx_data` is new; held until `rx_ack`
- rx_ack  input  1  one-cycle strobe that clears `rx_valid`
- rx_overrun  output  1  sticky overrun flag (see Configuration)
- busy  output  1  a transaction is in progress (state ACTIVE)

## Operation
- **Synchronizers:** `sclk`, `csb` and `din` each pass through a 2-flop synchronizer plus one history flop. Edges are detected from synchronized stage 2 versus stage 3.
- **Edge definitions:** the leading edge is the sclk transition away from CPOL. The trailing edge is the transition back to CPOL.
- **States:**
  - WAIT_HIGH is entered from reset. Go to IDLE once the synchronized `csb` reads 1.
  - In IDLE, a synchronized `csb` fall moves to ACTIVE.
  - In ACTIVE, a synchronized `csb` rise moves to IDLE.
- **Word start:** a word starts on the `csb` fall, or on word completion while `csb` stays low.
  - The holding register is copied into the TX shift register.
  - The bit counter is cleared and `tx_ready` is set.
  - If no `tx_load` occurred since the previous word start, the same holding value is resent.
- **CPHA=0:**
  - `dout` shows the TX MSB from word start.
  - Each leading edge samples `din` into the RX shift register.
  - Each trailing edge shifts TX, except the trailing edge after the final sample.
- **CPHA=1:**
  - Each leading edge shifts TX; the first leading edge presents the MSB.
  - Each trailing edge samples `din`.
- **Bit counter:** width is clog2(DATA_WIDTH)+1. It increments on each sample edge.
- **Word completion:** when the count reaches DATA_WIDTH, the RX shift register and the just-sampled bit go to `rx_data`, and `rx_valid` is set.
- **`dout` in IDLE/WAIT_HIGH:** driven 0.
- **`tx_load` and word start in the same cycle:** the new `tx_data` goes straight to the shift register and `tx_ready` stays 1.
- **`tx_load` otherwise:** writes the holding register and clears `tx_ready`.
- **`rx_ack` together with word completion:** `rx_valid` stays 1, carrying the new word.
- **`csb` rise mid-word:** the partial word is discarded. `rx_valid`, `rx_data` and the overrun flag are unchanged, and the counter is cleared.
- **Reset mid-transaction:** the block goes to WAIT_HIGH and ignores the current frame until `csb` returns high.

## Timing
- **Reset values:** `dout`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `rx_overrun`=0, `busy`=0, holding register=0.
- **Pin-to-detect latency:** a pin edge is acted on 3 `clk` cycles later; the registered effect is visible on the 4th.
- **`dout` after a shift edge:** valid 4 `clk` cycles after the causing `sclk` pin edge.
- **Master requirements:**
  - `sclk` high and low phases must each be ≥4 `clk` periods.
  - The `csb` fall to first `sclk` edge gap must be ≥4 `clk` periods.
  - The last `sclk` edge to `csb` rise gap must be ≥4 `clk` periods.
- **`rx_valid`:** rises 4 `clk` cycles after the final sample edge at the pin. It clears the cycle after `rx_ack`.
- **`busy`:** rises 4 cycles after the `csb` pin fall and falls 4 cycles after the `csb` pin rise.

## Configuration
- **SPI_SLAVE_SYNC_OVERRUN_EN defined:** if a word completes while `rx_valid`=1 and there is no `rx_ack` that cycle, `rx_data` is overwritten and `rx_overrun` is set.
  - `rx_overrun` clears only on reset or on an `rx_ack` issued while `rx_valid`=1.
- **Undefined:** `rx_overrun` is tied to 0, and later words overwrite `rx_data` silently.

## Test plan
- **Mode 0 exchange:** CPOL=0, CPHA=0, preload `tx_data`=0x3C, master sends 0xA5 at 4 `clk` per half-period. Master must receive 0x3C, `rx_data` must be 0xA5, and `rx_valid` must pulse high until `rx_ack`.
- **All four modes:** preload 0x11/0x22/0x33/0x44 per mode, master sends 0xA5. Every mode returns the matching pattern, and `rx_data`=0xA5.
- **Back-to-back words:** two words with `csb` held low. Load 0x5A before the first word and 0xC3 after `tx_ready` rises; the master sends 0x01 then 0x02. The master sees 0x5A then 0xC3, and `rx_data` goes 0x01 then 0x02.
- **Abort:** `csb` rises after 3 `sclk` cycles. There is no `rx_valid`, `rx_data` keeps its prior value, and the next full word 0x96 is received correctly.
- **Overrun:** send two words with no `rx_ack`. With SPI_SLAVE_SYNC_OVERRUN_EN, `rx_overrun`=1 and `rx_data` holds the second word. Without the macro, `rx_overrun`=0.
- **Reset mid-frame:** assert `resetb`=0 for 2 cycles mid-word while `csb` stays low. All outputs return to their reset values, and no word completes until `csb` cycles high then low.
